// File: rtl/instr_fetch.sv
// Instruction fetch unit: owns the PC, fetches words over a req/ack handshake and presents them downstream.
// Optional performance counters are enabled by defining INSTR_FETCH_PERF_EN.
module instr_fetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        i_clk,
    input  logic        i_rst,
    output logic        o_imem_req,
    output logic [31:0] o_imem_addr,
    input  logic        i_imem_ack,
    input  logic [31:0] i_imem_rdata,
    output logic        o_valid,
    input  logic        i_ready,
    output logic [31:0] o_instr,
    output logic [5:0]  o_op,
    output logic [31:0] o_pc,
    output logic [31:0] o_pc_plus4,
    input  logic        i_pcsrc,
    input  logic        i_jump,
    input  logic [31:0] i_signimm,
    output logic [31:0] o_instr_count,
    output logic [31:0] o_stall_count
);

    localparam logic [0:0] FETCH = 1'b0;
    localparam logic [0:0] HOLD  = 1'b1;

    logic [0:0]  state;
    logic [31:0] pc_reg;
    logic [31:0] instr_reg;
    logic [31:0] pc_plus4;
    logic [31:0] next_pc;
    logic        fetch_done;
    logic        accept;

    assign pc_plus4   = pc_reg + 32'd4;
    assign fetch_done = (state == FETCH) && i_imem_ack;
    assign accept     = (state == HOLD) && i_ready;

    // Jump wins over a taken branch; both are relative to the presented instruction.
    always_comb begin
        next_pc = pc_plus4;
        if (i_jump) begin
            next_pc = {pc_plus4[31:28], instr_reg[25:0], 2'b00};
        end else if (i_pcsrc) begin
            next_pc = pc_plus4 + {i_signimm[29:0], 2'b00};
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state     <= FETCH;
            pc_reg    <= RESET_PC;
            instr_reg <= '0;
        end else begin
            case (state)
                FETCH: begin
                    if (fetch_done) begin
                        instr_reg <= i_imem_rdata;
                        state     <= HOLD;
                    end
                end
                HOLD: begin
                    if (accept) begin
                        pc_reg <= next_pc;
                        state  <= FETCH;
                    end
                end
                default: state <= FETCH;
            endcase
        end
    end

    // Gated by reset so the reset cycle itself shows no request and no valid instruction.
    assign o_imem_req  = !i_rst && (state == FETCH);
    assign o_imem_addr = pc_reg;
    assign o_valid     = !i_rst && (state == HOLD);
    assign o_instr     = i_rst ? 32'h0 : instr_reg;
    assign o_op        = o_instr[31:26];
    assign o_pc        = pc_reg;
    assign o_pc_plus4  = pc_plus4;

`ifdef INSTR_FETCH_PERF_EN
    logic [31:0] instr_count;
    logic [31:0] stall_count;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            instr_count <= '0;
            stall_count <= '0;
        end else begin
            if (accept) begin
                instr_count <= instr_count + 32'd1;
            end
            if ((state == FETCH) && !i_imem_ack) begin
                stall_count <= stall_count + 32'd1;
            end
        end
    end

    assign o_instr_count = instr_count;
    assign o_stall_count = stall_count;
`else
    assign o_instr_count = 32'h0;
    assign o_stall_count = 32'h0;
`endif

endmodule

// File: doc/instr_fetch.md
# instr_fetch

Instruction fetch unit for the MIPS-subset core: owns the program counter, reads instruction words from instruction memory over a req/ack handshake, and presents each word, opcode field included, to the main control decoder and datapath with a valid/ready handshake. It sits on the upstream side of the opcode decoder. It also takes back the decoded branch and jump outcomes to select the next PC.

## Interface
Parameters:
- RESET_PC, 32'h0000_0000, byte address of the first fetch after reset; bits [1:0] must be 0.

Ports:
- i_clk  input  1  clock; all logic on rising edge.
- i_rst  input  1  synchronous, active-high reset.
- o_imem_req  output  1  read request to instruction memory.
- o_imem_addr  output  32  word-aligned byte address of the request.
- i_imem_ack  input  1  one-cycle pulse; i_imem_rdata valid in that cycle.
- i_imem_rdata  input  32  instruction word.
- o_valid  output  1  o_instr/o_pc/o_pc_plus4 hold a fetched instruction.
- i_ready  input  1  downstream accepts the presented instruction this cycle.
- o_instr  output  32  fetched instruction word.
- o_op  output  6  o_instr[31:26], wired to the decoder opcode input.
- o_pc  output  32  address of o_instr.
- o_pc_plus4  output  32  o_pc + 4.
- i_pcsrc  input  1  taken branch (decoder branch AND ALU zero) for the presented instruction.
- i_jump  input  1  decoded jump for the presented instruction.
- i_signimm  input  32  sign-extended immediate of the presented instruction.
- o_instr_count  output  32  accepted-instruction counter (INSTR_FETCH_PERF_EN only).
- o_stall_count  output  32  memory-wait cycle counter (INSTR_FETCH_PERF_EN only).

## Operation
- FSM with 2 states: FETCH and HOLD.
- FETCH: o_imem_req=1, o_imem_addr=pc_reg, o_valid=0. While FETCH is held, o_imem_addr stays stable until ack. On i_imem_ack, the unit latches i_imem_rdata into o_instr and moves to HOLD.
- HOLD: o_imem_req=0, o_valid=1. Outputs stay stable until i_ready.
- On i_ready in HOLD, the unit latches next PC into pc_reg and moves to FETCH.
- Next PC selection, with i_jump over i_pcsrc over sequential:
  - i_jump: {o_pc_plus4[31:28], o_instr[25:0], 2'b00}.
  - i_pcsrc: o_pc_plus4 + (i_signimm << 2).
  - otherwise: o_pc_plus4.
- i_jump, i_pcsrc and i_signimm are sampled only in the HOLD & i_ready cycle and ignored otherwise.
- All PC arithmetic is 32-bit modulo. 32'hFFFF_FFFC + 4 wraps to 0. A branch target overflows silently.
- i_imem_ack in HOLD is ignored, and so is i_imem_ack in any cycle with i_rst=1.
- At most one outstanding request. The memory must not ack without a request.
- o_op is purely combinational from o_instr.

## Timing
- Reset values:
  - state=FETCH, pc_reg=RESET_PC.
  - o_instr=0, o_valid=0, o_imem_req=0 during the reset cycle.
  - counters=0.
- The first cycle after i_rst deasserts has o_imem_req=1 and o_imem_addr=RESET_PC.
- Memory latency L ≥ 0 cycles after the request appears (L=0 means ack in the same cycle). o_valid rises the cycle after ack.
- Throughput is best case one instruction per 2 cycles: with L=0 and i_ready tied high, instructions alternate FETCH/HOLD.
- Redirect takes effect on the very next request; no wrong-path fetch ever occurs.
- Reset mid-FETCH drops the outstanding request. Memory shares i_rst and aborts too.
- Reset mid-HOLD discards the presented instruction. o_valid=0 the cycle i_rst is sampled.

## Configuration
- INSTR_FETCH_PERF_EN defined:
  - o_instr_count increments on each HOLD & i_ready cycle.
  - o_stall_count increments on each FETCH cycle without i_imem_ack.
  - Both are 32-bit, wrap modulo 2^32, and clear on i_rst.
- INSTR_FETCH_PERF_EN undefined: both outputs are tied to 32'h0 and no counter flops are synthesized.

## Test plan
- Sequential fetch: memory with L=0, i_ready=1, words 0x20080005, 0x20090003. Required: o_pc 0x0, then 0x4; o_op 6'b001000 both; o_valid every other cycle.
- Variable latency and backpressure: ack 3 cycles late, i_ready low 4 cycles in HOLD. Required: o_imem_addr stable through the wait; o_instr/o_pc stable while o_valid=1 & !i_ready; o_stall_count=3 with PERF_EN.
- Branch taken: instr at 0x10, i_pcsrc=1, i_signimm=32'hFFFF_FFFD. Required: next o_imem_addr=0x08. Same instr with i_pcsrc=0 gives 0x14.
- Jump priority: instr 0x08000040 at 0x3000_0000, i_jump=1 and i_pcsrc=1 together. Required: next addr 0x3000_0100.
- Wrap-around: RESET_PC=32'hFFFF_FFFC, sequential accept. Required: o_pc_plus4=0 and next addr 0x0.
- Reset mid-operation: assert i_rst in FETCH awaiting ack, with an ack arriving the same cycle. Required: ack ignored; o_valid=0; next request at RESET_PC; counters 0.
